// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing defaults, coordinate width and the phase
// encoding used by both the horizontal and vertical phase FSMs.
package vga_pkg;

  localparam int COORD_W = 11;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

endpackage

// File: rtl/vga_phase_fsm.sv
// Raster phase tracker for one axis. The phase always describes the
// counter value currently held by the parent, so each transition is
// taken on the advance that moves the counter onto the first value of
// the next region.
module vga_phase_fsm
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [COORD_W-1:0] cnt,
  output phase_t             phase,
  output logic               in_sync,
  output logic               in_active,
  output logic               wrap
);

  localparam logic [COORD_W-1:0] LAST_ACT  = COORD_W'(ACTIVE - 1);
  localparam logic [COORD_W-1:0] LAST_FP   = COORD_W'(ACTIVE + FP - 1);
  localparam logic [COORD_W-1:0] LAST_SYNC = COORD_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [COORD_W-1:0] LAST_CNT  = COORD_W'(ACTIVE + FP + SYNC + BP - 1);

  phase_t phase_q;
  phase_t phase_d;

  // Phase register, back to ACTIVE on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= PH_ACTIVE;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Next phase: move on when the counter leaves the last value of a region.
  always_comb begin
    phase_d = phase_q;
    if (en) begin
      case (phase_q)
        PH_ACTIVE: if (cnt == LAST_ACT)  phase_d = PH_FRONT;
        PH_FRONT:  if (cnt == LAST_FP)   phase_d = PH_SYNC;
        PH_SYNC:   if (cnt == LAST_SYNC) phase_d = PH_BACK;
        PH_BACK:   if (cnt == LAST_CNT)  phase_d = PH_ACTIVE;
        default:                         phase_d = PH_ACTIVE;
      endcase
    end
  end

  assign phase     = phase_q;
  assign in_sync   = (phase_q == PH_SYNC);
  assign in_active = (phase_q == PH_ACTIVE);
  assign wrap      = (cnt == LAST_CNT);

endmodule

// File: rtl/vga_sync_timing.sv
// VGA raster timing: pixel-rate divider, col/row counters, H/V phase
// FSMs and the one-tick output stage that aligns hsync/vsync/video_on
// with the pattern RGB returned for the previous coordinate.
module vga_sync_timing
  import vga_pkg::*;
#(
  parameter int   PIX_DIV     = 4,
  parameter int   H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int   H_FP        = vga_pkg::H_FP,
  parameter int   H_SYNC      = vga_pkg::H_SYNC,
  parameter int   H_BP        = vga_pkg::H_BP,
  parameter int   V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int   V_FP        = vga_pkg::V_FP,
  parameter int   V_SYNC      = vga_pkg::V_SYNC,
  parameter int   V_BP        = vga_pkg::V_BP,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         red_in,
  input  logic [3:0]         green_in,
  input  logic [3:0]         blue_in,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               pix_tick,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue
);

  localparam int DIV_W = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0]   div_q;
  logic               adv;
  logic [COORD_W-1:0] col_p0;
  logic [COORD_W-1:0] row_p0;
  logic               vld_p0;
  logic               frame_p0;

  phase_t             h_phase;
  phase_t             v_phase;
  logic               h_in_sync;
  logic               v_in_sync;
  logic               h_in_active;
  logic               v_in_active;
  logic               h_wrap;
  logic               v_wrap;

  logic               hs_raw;
  logic               vs_raw;
  logic               on_raw;

  logic               hsync_p1;
  logic               vsync_p1;
  logic               video_on_p1;
  logic [3:0]         red_p1;
  logic [3:0]         green_p1;
  logic [3:0]         blue_p1;

  // Pixel-rate divider; the advance fires on its last count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign adv = (div_q == DIV_LAST);

  // ---- stage p0: coordinates and tick strobes ----
  // Coordinate counters; col wraps at line end and carries into row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (adv) begin
      if (h_wrap) begin
        col_p0 <= '0;
        row_p0 <= v_wrap ? '0 : row_p0 + 1'b1;
      end else begin
        col_p0 <= col_p0 + 1'b1;
      end
    end
  end

  // Tick and frame-start strobes, high only for the clk the coordinates move.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0   <= 1'b0;
      frame_p0 <= 1'b0;
    end else begin
      vld_p0   <= adv;
      frame_p0 <= adv & h_wrap & v_wrap;
    end
  end

  vga_phase_fsm #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_fsm (
    .clk       (clk),
    .rst       (rst),
    .en        (adv),
    .cnt       (col_p0),
    .phase     (h_phase),
    .in_sync   (h_in_sync),
    .in_active (h_in_active),
    .wrap      (h_wrap)
  );

  vga_phase_fsm #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_fsm (
    .clk       (clk),
    .rst       (rst),
    .en        (adv & h_wrap),
    .cnt       (row_p0),
    .phase     (v_phase),
    .in_sync   (v_in_sync),
    .in_active (v_in_active),
    .wrap      (v_wrap)
  );

  assign hs_raw = h_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vs_raw = v_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign on_raw = h_in_active & v_in_active;

  // ---- stage p1: connector outputs for the previous coordinate ----
  // Syncs, video_on and blanked RGB all sampled on the same advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_p1    <= ~SYNC_ACTIVE;
      vsync_p1    <= ~SYNC_ACTIVE;
      video_on_p1 <= 1'b0;
      red_p1      <= '0;
      green_p1    <= '0;
      blue_p1     <= '0;
    end else if (adv) begin
      hsync_p1    <= hs_raw;
      vsync_p1    <= vs_raw;
      video_on_p1 <= on_raw;
      red_p1      <= on_raw ? red_in   : 4'h0;
      green_p1    <= on_raw ? green_in : 4'h0;
      blue_p1     <= on_raw ? blue_in  : 4'h0;
    end
  end

  assign col         = col_p0;
  assign row         = row_p0;
  assign pix_tick    = vld_p0;
  assign frame_start = frame_p0;
  assign hsync       = hsync_p1;
  assign vsync       = vsync_p1;
  assign video_on    = video_on_p1;
  assign red         = red_p1;
  assign green       = green_p1;
  assign blue        = blue_p1;

  // The phase encodings themselves are only needed as the in_* flags.
  logic unused_phase;
  assign unused_phase = ^{h_phase, v_phase};

endmodule

// File: tb/tb_vga_sync_timing.sv
// Directed bench for vga_sync_timing: a full-size instance fed by a
// colour-stripe source and a reduced-geometry instance that makes
// whole frames affordable.
module tb_vga_sync_timing;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Full 640x480 instance.
  logic [3:0]  d_red_in, d_green_in, d_blue_in;
  logic [10:0] d_col, d_row;
  logic        d_tick, d_fs, d_hs, d_vs, d_von;
  logic [3:0]  d_red, d_green, d_blue;

  // Reduced geometry: 25 ticks per line, 17 lines per frame.
  logic [3:0]  s_red_in, s_green_in, s_blue_in;
  logic [10:0] s_col, s_row;
  logic        s_tick, s_fs, s_hs, s_vs, s_von;
  logic [3:0]  s_red, s_green, s_blue;

  vga_sync_timing dut (
    .clk(clk), .rst(rst_n),
    .red_in(d_red_in), .green_in(d_green_in), .blue_in(d_blue_in),
    .col(d_col), .row(d_row), .pix_tick(d_tick), .frame_start(d_fs),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
    .red(d_red), .green(d_green), .blue(d_blue)
  );

  vga_sync_timing #(
    .PIX_DIV(2),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_s (
    .clk(clk), .rst(rst_n),
    .red_in(s_red_in), .green_in(s_green_in), .blue_in(s_blue_in),
    .col(s_col), .row(s_row), .pix_tick(s_tick), .frame_start(s_fs),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
    .red(s_red), .green(s_green), .blue(s_blue)
  );

  assign s_red_in   = 4'hF;
  assign s_green_in = 4'h0;
  assign s_blue_in  = 4'hF;

  // Stripe source: registered colour one clk after the coordinate; cmode
  // switches it to a constant magenta.
  logic       cmode;
  logic [2:0] sidx;
  assign sidx = 3'(d_col / 11'd80);

  always_ff @(posedge clk) begin
    if (cmode) begin
      d_red_in   <= 4'hF;
      d_green_in <= 4'h0;
      d_blue_in  <= 4'hF;
    end else begin
      d_red_in   <= sidx[2] ? 4'hF : 4'h0;
      d_green_in <= sidx[1] ? 4'hF : 4'h0;
      d_blue_in  <= sidx[0] ? 4'hF : 4'h0;
    end
  end

  // Monitor mux: sel=0 full instance, sel=1 reduced instance.
  logic        sel;
  logic [10:0] m_col, m_row;
  logic        m_tick, m_fs, m_hs, m_vs, m_von;
  logic [3:0]  m_red, m_green, m_blue;

  always_comb begin
    m_col = d_col; m_row = d_row; m_tick = d_tick; m_fs = d_fs;
    m_hs = d_hs; m_vs = d_vs; m_von = d_von;
    m_red = d_red; m_green = d_green; m_blue = d_blue;
    if (sel) begin
      m_col = s_col; m_row = s_row; m_tick = s_tick; m_fs = s_fs;
      m_hs = s_hs; m_vs = s_vs; m_von = s_von;
      m_red = s_red; m_green = s_green; m_blue = s_blue;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic reset_chk();
    chk("rst_col", m_col, 0);
    chk("rst_row", m_row, 0);
    chk("rst_tick", m_tick, 0);
    chk("rst_fs", m_fs, 0);
    chk("rst_hsync", m_hs, 1);
    chk("rst_vsync", m_vs, 1);
    chk("rst_video_on", m_von, 0);
    chk("rst_rgb", {m_red, m_green, m_blue}, 0);
  endtask

  // Walks n_ticks pixel ticks from reset release, checking every tick
  // against the raster arithmetic: outputs describe coordinate n-1.
  task automatic run_ticks(input int n_ticks, input int pdiv,
                           input int hact, input int hfp, input int hsy, input int htot,
                           input int vact, input int vfp, input int vsy, input int vtot,
                           input bit stripe0);
    int clks, pc, pr, idx, hs_low, von_cnt, vs_low;
    bit on;
    logic [3:0] er, eg, eb;
    hs_low = 0; von_cnt = 0; vs_low = 0;
    for (int n = 1; n <= n_ticks; n++) begin
      clks = 0;
      do begin
        @(negedge clk);
        clks++;
      end while (!m_tick && clks < pdiv + 2);
      chk("tick_gap", clks, pdiv);
      pc = (n - 1) % htot;
      pr = ((n - 1) / htot) % vtot;
      on = (pc < hact) && (pr < vact);
      chk("col", m_col, n % htot);
      chk("row", m_row, (n / htot) % vtot);
      chk("frame_start", m_fs, (n % (htot * vtot)) == 0);
      chk("hsync", m_hs, !((pc >= hact + hfp) && (pc < hact + hfp + hsy)));
      chk("vsync", m_vs, !((pr >= vact + vfp) && (pr < vact + vfp + vsy)));
      chk("video_on", m_von, on);
      er = 4'h0; eg = 4'h0; eb = 4'h0;
      if (on) begin
        if (stripe0 && pr == 0) begin
          idx = pc / 80;
          er = idx[2] ? 4'hF : 4'h0;
          eg = idx[1] ? 4'hF : 4'h0;
          eb = idx[0] ? 4'hF : 4'h0;
        end else begin
          er = 4'hF; eb = 4'hF;
        end
      end
      chk("red", m_red, er);
      chk("green", m_green, eg);
      chk("blue", m_blue, eb);
      if (!m_hs) hs_low++;
      if (m_von) von_cnt++;
      if (!m_vs) vs_low++;
      if (n % htot == 0) begin
        chk("hsync_low_per_line", hs_low, hsy);
        chk("video_on_per_line", von_cnt, (pr < vact) ? hact : 0);
        hs_low = 0; von_cnt = 0;
      end
      if (n % (htot * vtot) == 0) begin
        chk("vsync_low_per_frame", vs_low, vsy * htot);
        vs_low = 0;
      end
      if (stripe0 && n == htot) cmode = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cmode = 1'b0;
    sel   = 1'b0;
    repeat (3) @(negedge clk);
    reset_chk();
    sel = 1'b1;
    #1;
    reset_chk();
    sel = 1'b0;

    // Full geometry: stripe line, then constant colour, to row 2 col 400.
    @(negedge clk);
    rst_n = 1'b1;
    run_ticks(2000, 4, 640, 16, 96, 800, 480, 10, 2, 525, 1'b1);

    // Mid-frame reset with video active, then restart from col=1.
    rst_n = 1'b0;
    #1;
    reset_chk();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_ticks(20, 4, 640, 16, 96, 800, 480, 10, 2, 525, 1'b0);

    // Reduced geometry: two whole frames, stopping inside both sync pulses.
    sel   = 1'b1;
    rst_n = 1'b0;
    #1;
    reset_chk();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_ticks(1170, 2, 16, 2, 4, 25, 10, 2, 2, 17, 1'b0);
    chk("pre_rst_hsync_low", m_hs, 0);
    chk("pre_rst_vsync_low", m_vs, 0);

    rst_n = 1'b0;
    #1;
    reset_chk();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_ticks(30, 2, 16, 2, 4, 25, 10, 2, 2, 17, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_timing.md
Name: vga_sync_timing

Overview:
Generates 640x480@60 VGA raster timing and drives the pixel coordinates (row, col) consumed by the colour pattern generators, such as the colour-stripe source. It accepts their registered 4-bit RGB back, aligns it with hsync/vsync and blanks it outside the active area. It sits between the pattern generators and the VGA connector pins, running from the 100 MHz system clock with an internal pixel-rate enable.

Parameters:
PIX_DIV, 4, system clocks per pixel (tick every PIX_DIV clk cycles); legal range >= 2
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, level of hsync/vsync during the sync pulse (0 = active-low)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
red_in  in  4  pattern red for the current row/col
green_in  in  4  pattern green
blue_in  in  4  pattern blue
col  out  11  horizontal pixel counter, 0..H_TOTAL-1
row  out  11  vertical line counter, 0..V_TOTAL-1
pix_tick  out  1  one-clk pulse marking each pixel-rate advance
frame_start  out  1  one-clk pulse, coincident with pix_tick, when col and row both wrap to 0
hsync  out  1  horizontal sync to the connector
vsync  out  1  vertical sync to the connector
video_on  out  1  high while the RGB outputs carry active pixels
red  out  4  blanked red to the connector
green  out  4  blanked green
blue  out  4  blanked blue

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (rst=0, async): divider=0, col=0, row=0, pix_tick=0, frame_start=0, red/green/blue=0, video_on=0, hsync=vsync=!SYNC_ACTIVE, H and V FSMs in ACTIVE.
- Divider: counts 0..PIX_DIV-1 and wraps. pix_tick is registered and high for one clk when the divider equals PIX_DIV-1.
- On each pix_tick:
  - col increments.
  - When col = H_TOTAL-1, col wraps to 0 and row increments.
  - When row = V_TOTAL-1 at that wrap, row also wraps to 0.
  - frame_start is asserted for the tick on which col and row both become 0.
  - col and row never exceed H_TOTAL-1 and V_TOTAL-1.
- H FSM (advances on pix_tick), driven by col:
  - ACTIVE (col < 640) -> FRONT at col=640.
  - FRONT -> SYNC at col=656.
  - SYNC -> BACK at col=752.
  - BACK -> ACTIVE at the col wrap.
- V FSM (advances only on the pix_tick where col wraps), driven by row, with the same pattern:
  - ACTIVE (row < 480) -> FRONT at 480.
  - FRONT -> SYNC at 490.
  - SYNC -> BACK at 492.
  - BACK -> ACTIVE at the row wrap.
- Internal flags:
  - hs_raw = SYNC_ACTIVE while H=SYNC (col 656..751).
  - vs_raw = SYNC_ACTIVE while V=SYNC (row 490..491).
  - on_raw = (H=ACTIVE && V=ACTIVE).
- Output alignment (latency = 1 pixel tick):
  - Pattern generators register RGB one clk after row/col change. Because PIX_DIV >= 2, red_in/green_in/blue_in are stable by the next pix_tick.
  - On each pix_tick, register hsync<=hs_raw, vsync<=vs_raw and video_on<=on_raw, all from the previous coordinate.
  - On the same pix_tick, register red/green/blue <= on_raw ? *_in : 0.
  - Result: connector outputs for coordinate (r,c) appear one tick after col=c, row=r is driven.
- Between ticks, every output except pix_tick and frame_start holds its value.
- Reset mid-frame: everything returns to the reset values immediately. After release, the first pix_tick occurs PIX_DIV clks later, and counting resumes at col=1, row=0.
- hsync/vsync are glitch-free: they are always driven straight from flops.

Decomposition:
- Shared package vga_pkg holds:
  - the 640x480 timing defaults (H_ACTIVE..V_BP, H_TOTAL, V_TOTAL);
  - the COORD_W = 11 width constant;
  - the phase state encoding ACTIVE/FRONT/SYNC/BACK, shared by the H and V FSMs.
- One sub-module is natural: vga_phase_fsm, parameterised by ACTIVE/FP/SYNC/BP. It takes the advance enable and the counter, and returns the phase, sync, active and wrap flags. It is instantiated twice, once for H and once for V.

Test Plan:
- Reset then run 4*800 clks -> pix_tick every 4th clk; col sweeps 0..799 and wraps to 0; row = 1 after the wrap.
- One full line -> hsync low for exactly 96 ticks; its falling edge is observed one tick after col=656 was driven; video_on high for exactly 640 ticks per line.
- Full frame (4*800*525 clks) -> vsync low for exactly 2*800 ticks, starting one tick after row=490, col=0; exactly one frame_start per 420000 ticks.
- Constant red_in=4'hF, green_in=0, blue_in=4'hF -> red=4'hF and blue=4'hF while video_on=1; red=green=blue=0 during col 640..799 and row 480..524.
- rst=0 asserted at row=300, col=400 -> outputs immediately at reset values (hsync=vsync=1); after release, the first tick gives col=1, row=0.
- Stripe source connected -> red=green=blue=0 at col 0..79; blue=4'hF only at col 80..159; all 4'hF at col 560..639, with each pixel appearing one tick after its coordinate.
